// File: rtl/time_clock_core_pkg.sv
// Shared widths, limits, OPER bit layout and field arithmetic for the
// hh:mm:ss clock.
package time_clock_core_pkg;

    localparam int FIELD_W = 6;
    localparam int TIME_W  = 3 * FIELD_W;
    localparam int OPER_W  = TIME_W + 3;
    localparam int BCD_W   = 24;

    localparam logic [FIELD_W-1:0] HOUR_MAX = 6'd23;
    localparam logic [FIELD_W-1:0] MIN_MAX  = 6'd59;
    localparam logic [FIELD_W-1:0] SEC_MAX  = 6'd59;

    localparam int OPER_CLR       = 0;
    localparam int OPER_DEC       = 1;
    localparam int OPER_VALID     = 2;
    localparam int OPER_DELTA_LSB = 3;

    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 6;
    localparam int HOUR_LSB = 12;

    localparam int BTN_W     = 7;
    localparam int BTN_DSEC  = 0;
    localparam int BTN_ISEC  = 1;
    localparam int BTN_DMIN  = 2;
    localparam int BTN_IMIN  = 3;
    localparam int BTN_DHOUR = 4;
    localparam int BTN_IHOUR = 5;
    localparam int BTN_CLR   = 6;

    typedef logic [FIELD_W-1:0] field_t;

    typedef struct packed {
        field_t hour;
        field_t min;
        field_t sec;
    } time_t;

    typedef logic [OPER_W-1:0] oper_t;

    // Manual adjust: wraps inside the field, never touches its neighbours.
    function automatic field_t step_field(input field_t value, input field_t max, input logic dec);
        if (dec)
            return (value == '0) ? max : value - 6'd1;
        return (value >= max) ? '0 : value + 6'd1;
    endfunction

    function automatic time_t tick_advance(input time_t t);
        time_t r;
        r = t;
        if (t.sec >= SEC_MAX) begin
            r.sec = '0;
            if (t.min >= MIN_MAX) begin
                r.min  = '0;
                r.hour = (t.hour >= HOUR_MAX) ? '0 : t.hour + 6'd1;
            end else begin
                r.min = t.min + 6'd1;
            end
        end else begin
            r.sec = t.sec + 6'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input field_t value);
        field_t tens;
        field_t ones;
        tens = value / 6'd10;
        ones = value - tens * 6'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/time_clock_core_if.sv
// Button inputs and time/display outputs of the clock core.
interface time_clock_core_if;
    import time_clock_core_pkg::*;

    logic                ihour;
    logic                dhour;
    logic                imin;
    logic                dmin;
    logic                isec;
    logic                dsec;
    logic                reset_time;
    logic [TIME_W-1:0]   curr_time;
    logic [BCD_W-1:0]    disp_bcd;
    logic                disp_upd;

    modport master (
        output ihour, dhour, imin, dmin, isec, dsec, reset_time,
        input  curr_time, disp_bcd, disp_upd
    );

    modport slave (
        input  ihour, dhour, imin, dmin, isec, dsec, reset_time,
        output curr_time, disp_bcd, disp_upd
    );
endinterface

// File: rtl/time_clock_core_input_driver.sv
// Button front-end: registers the buttons, detects rising edges and
// encodes the highest-priority edge into a one-cycle OPER pulse.
module tc_input_driver
    import time_clock_core_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BTN_W-1:0] buttons,
    output oper_t            oper
);

    logic [BTN_W-1:0] btn_reg;
    logic [BTN_W-1:0] btn_prev_reg;
    logic [BTN_W-1:0] rise;
    oper_t            oper_reg;
    oper_t            oper_next;
    time_t            delta;
    logic             valid;
    logic             dec;
    logic             clr;

    assign rise = btn_reg & ~btn_prev_reg;

    // Within a field the increment wins, so DEC is set only when the
    // increment button of that field did not rise.
    always_comb begin
        delta = '0;
        valid = 1'b0;
        dec   = 1'b0;
        clr   = 1'b0;
        if (rise[BTN_CLR]) begin
            clr = 1'b1;
        end else if (rise[BTN_IHOUR] || rise[BTN_DHOUR]) begin
            valid      = 1'b1;
            delta.hour = 6'd1;
            dec        = ~rise[BTN_IHOUR];
        end else if (rise[BTN_IMIN] || rise[BTN_DMIN]) begin
            valid     = 1'b1;
            delta.min = 6'd1;
            dec       = ~rise[BTN_IMIN];
        end else if (rise[BTN_ISEC] || rise[BTN_DSEC]) begin
            valid     = 1'b1;
            delta.sec = 6'd1;
            dec       = ~rise[BTN_ISEC];
        end
        oper_next = {delta, valid, dec, clr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_reg      <= '0;
            btn_prev_reg <= '0;
            oper_reg     <= '0;
        end else begin
            btn_reg      <= buttons;
            btn_prev_reg <= btn_reg;
            oper_reg     <= oper_next;
        end
    end

    assign oper = oper_reg;

endmodule

// File: rtl/time_clock_core_output_driver.sv
// Display register: BCD of the current time plus a strobe on every change.
module tc_output_driver
    import time_clock_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] curr_time,
    output logic [BCD_W-1:0]  disp_bcd,
    output logic              disp_upd
);

    logic [BCD_W-1:0] bcd_next;
    logic [BCD_W-1:0] disp_bcd_reg;
    logic             disp_upd_reg;

    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
        assign bcd_next[gi*8 +: 8] = to_bcd(curr_time[gi*FIELD_W +: FIELD_W]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_bcd_reg <= '0;
            disp_upd_reg <= 1'b0;
        end else begin
            disp_bcd_reg <= bcd_next;
            disp_upd_reg <= (bcd_next != disp_bcd_reg);
        end
    end

    assign disp_bcd = disp_bcd_reg;
    assign disp_upd = disp_upd_reg;

endmodule

// File: rtl/time_clock_core_time_handler.sv
// Time register: applies clear / manual adjust / one-second ticks, with a
// pending tick so a second is never lost to a simultaneous adjust.
module tc_time_handler
    import time_clock_core_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  oper_t oper,
    output time_t curr_time
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             pending_reg;
    logic             pending_next;
    time_t            time_reg;
    time_t            time_next;
    time_t            delta;
    logic             tick;
    logic             advance;

    assign delta   = oper[OPER_W-1:OPER_DELTA_LSB];
    assign tick    = (cnt_reg == CNT_TOP);
    assign advance = tick | pending_reg;

    always_comb begin
        cnt_next     = tick ? '0 : cnt_reg + 1'b1;
        pending_next = pending_reg;
        time_next    = time_reg;
        if (oper[OPER_CLR]) begin
            time_next    = '0;
            cnt_next     = '0;
            pending_next = 1'b0;
        end else if (oper[OPER_VALID]) begin
            if (|delta.hour)
                time_next.hour = step_field(time_reg.hour, HOUR_MAX, oper[OPER_DEC]);
            else if (|delta.min)
                time_next.min = step_field(time_reg.min, MIN_MAX, oper[OPER_DEC]);
            else if (|delta.sec)
                time_next.sec = step_field(time_reg.sec, SEC_MAX, oper[OPER_DEC]);
            pending_next = advance;
        end else if (advance) begin
            time_next = tick_advance(time_reg);
            // A fresh tick landing on a pending one keeps one in reserve.
            pending_next = tick & pending_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            time_reg    <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            time_reg    <= time_next;
        end
    end

    assign curr_time = time_reg;

endmodule

// File: rtl/time_clock_core.sv
// hh:mm:ss clock core: button front-end -> time register -> BCD display.
module time_clock_core
    import time_clock_core_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic               clk,
    input  logic               rst,
    time_clock_core_if.slave   bus
);

    logic [BTN_W-1:0] buttons;
    oper_t            oper;
    time_t            curr_time;

    assign buttons = {bus.reset_time, bus.ihour, bus.dhour,
                      bus.imin, bus.dmin, bus.isec, bus.dsec};

    tc_input_driver u_input (
        .clk     (clk),
        .rst     (rst),
        .buttons (buttons),
        .oper    (oper)
    );

    tc_time_handler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_time (
        .clk       (clk),
        .rst       (rst),
        .oper      (oper),
        .curr_time (curr_time)
    );

    tc_output_driver u_output (
        .clk       (clk),
        .rst       (rst),
        .curr_time (curr_time),
        .disp_bcd  (bus.disp_bcd),
        .disp_upd  (bus.disp_upd)
    );

    assign bus.curr_time = curr_time;

endmodule

// File: tb/tb_time_clock_core.sv
// Directed bench: a slow-tick instance for button behaviour and a
// one-tick-per-cycle instance for the full-day rollover.
module tb_time_clock_core;

    localparam logic [6:0] M_DSEC  = 7'b0000001;
    localparam logic [6:0] M_ISEC  = 7'b0000010;
    localparam logic [6:0] M_DMIN  = 7'b0000100;
    localparam logic [6:0] M_IMIN  = 7'b0001000;
    localparam logic [6:0] M_DHOUR = 7'b0010000;
    localparam logic [6:0] M_IHOUR = 7'b0100000;
    localparam logic [6:0] M_CLR   = 7'b1000000;

    typedef struct {
        logic [6:0]  mask;
        logic [17:0] req;
    } vec_t;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic rst_fast = 1'b0;
    logic fast_done = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[12];

    time_clock_core_if bus_slow();
    time_clock_core_if bus_fast();

    time_clock_core #(.TICKS_PER_SEC(1000)) dut_slow (
        .clk (clk),
        .rst (rst),
        .bus (bus_slow)
    );

    time_clock_core #(.TICKS_PER_SEC(1)) dut_fast (
        .clk (clk),
        .rst (rst_fast),
        .bus (bus_fast)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] hms(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [23:0] bcd_of(input logic [17:0] t);
        int h, m, s;
        h = int'(t[17:12]);
        m = int'(t[11:6]);
        s = int'(t[5:0]);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic set_btn(input logic [6:0] m);
        {bus_slow.reset_time, bus_slow.ihour, bus_slow.dhour,
         bus_slow.imin, bus_slow.dmin, bus_slow.isec, bus_slow.dsec} = m;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic press(input logic [6:0] m);
        @(negedge clk) set_btn(m);
        @(negedge clk) set_btn(7'b0);
    endtask

    // Returns on the negedge right after the last press was registered.
    task automatic set_time(input int h, input int m, input int s);
        for (int i = 0; i < h; i++) press(M_IHOUR);
        for (int i = 0; i < m; i++) press(M_IMIN);
        for (int i = 0; i < s; i++) press(M_ISEC);
    endtask

    // Full-day rollover on the one-tick-per-cycle instance.
    initial begin
        {bus_fast.reset_time, bus_fast.ihour, bus_fast.dhour,
         bus_fast.imin, bus_fast.dmin, bus_fast.isec, bus_fast.dsec} = 7'b0;
        #1 rst_fast = 1'b1;
        @(negedge clk);
        @(negedge clk) rst_fast = 1'b0;
        repeat (86399) @(posedge clk);
        #1 check("fast_235959", {6'b0, bus_fast.curr_time}, {6'b0, hms(23, 59, 59)});
        $display("fast: after 86399 ticks time=%05h", bus_fast.curr_time);
        @(posedge clk);
        #1 check("fast_rollover", {6'b0, bus_fast.curr_time}, 24'h0);
        $display("fast: after 86400 ticks time=%05h", bus_fast.curr_time);
        fast_done = 1'b1;
    end

    initial begin
        vecs[0]  = '{M_DHOUR,           hms(23, 0, 0)};
        vecs[1]  = '{M_IHOUR,           hms(0, 0, 0)};
        vecs[2]  = '{M_DSEC,            hms(0, 0, 59)};
        vecs[3]  = '{M_ISEC,            hms(0, 0, 0)};
        vecs[4]  = '{M_DMIN,            hms(0, 59, 0)};
        vecs[5]  = '{M_IMIN,            hms(0, 0, 0)};
        vecs[6]  = '{M_IHOUR | M_DHOUR, hms(1, 0, 0)};
        vecs[7]  = '{M_IMIN | M_ISEC,   hms(1, 1, 0)};
        vecs[8]  = '{M_DHOUR | M_DSEC,  hms(0, 1, 0)};
        vecs[9]  = '{M_CLR | M_IHOUR,   hms(0, 0, 0)};
        vecs[10] = '{M_DMIN | M_DSEC,   hms(0, 59, 0)};
        vecs[11] = '{M_ISEC,            hms(0, 59, 1)};

        set_btn(7'b0);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_time", {6'b0, bus_slow.curr_time}, 24'h0);
        check("reset_bcd", bus_slow.disp_bcd, 24'h0);
        check("reset_upd", {23'b0, bus_slow.disp_upd}, 24'h0);
        @(negedge clk) rst = 1'b0;

        // Table: single-cycle presses, time at k+2, display at k+3.
        for (int i = 0; i < 12; i++) begin
            press(vecs[i].mask);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_time", i), {6'b0, bus_slow.curr_time}, {6'b0, vecs[i].req});
            @(negedge clk);
            check($sformatf("vec%0d_bcd", i), bus_slow.disp_bcd, bcd_of(vecs[i].req));
            $display("vec %0d: mask=%b time=%05h bcd=%06h", i, vecs[i].mask,
                     bus_slow.curr_time, bus_slow.disp_bcd);
        end

        // Holding IMIN produces exactly one increment.
        do_reset();
        @(negedge clk) set_btn(M_IMIN);
        repeat (20) @(negedge clk);
        check("hold_imin", {6'b0, bus_slow.curr_time}, {6'b0, hms(0, 1, 0)});
        set_btn(7'b0);
        repeat (3) @(negedge clk);
        check("hold_release", {6'b0, bus_slow.curr_time}, {6'b0, hms(0, 1, 0)});
        $display("hold: time=%05h", bus_slow.curr_time);

        // RESET_TIME beats IHOUR in the same cycle.
        do_reset();
        set_time(12, 34, 56);
        repeat (3) @(negedge clk);
        check("set_123456", {6'b0, bus_slow.curr_time}, {6'b0, hms(12, 34, 56)});
        press(M_CLR | M_IHOUR);
        @(negedge clk);
        @(negedge clk);
        check("clr_wins", {6'b0, bus_slow.curr_time}, 24'h0);
        $display("clr: time=%05h", bus_slow.curr_time);

        // Display feed and one-cycle strobe at 13:45:09.
        do_reset();
        set_time(13, 45, 9);
        @(negedge clk);
        @(negedge clk);
        check("set_134509", {6'b0, bus_slow.curr_time}, {6'b0, hms(13, 45, 9)});
        @(negedge clk);
        check("bcd_134509", bus_slow.disp_bcd, 24'h134509);
        check("upd_high", {23'b0, bus_slow.disp_upd}, 24'h1);
        @(negedge clk);
        check("upd_low", {23'b0, bus_slow.disp_upd}, 24'h0);
        check("bcd_hold", bus_slow.disp_bcd, 24'h134509);
        $display("disp: bcd=%06h upd=%b", bus_slow.disp_bcd, bus_slow.disp_upd);

        // Asynchronous reset between clock edges.
        do_reset();
        set_time(5, 6, 7);
        repeat (3) @(negedge clk);
        check("bcd_050607", bus_slow.disp_bcd, 24'h050607);
        #2 rst = 1'b1;
        #1;
        check("async_time", {6'b0, bus_slow.curr_time}, 24'h0);
        check("async_bcd", bus_slow.disp_bcd, 24'h0);
        check("async_upd", {23'b0, bus_slow.disp_upd}, 24'h0);
        $display("async reset: time=%05h bcd=%06h", bus_slow.curr_time, bus_slow.disp_bcd);
        @(negedge clk) rst = 1'b0;

        // Ticks every 1000 cycles; an adjust on a tick edge defers the tick.
        repeat (999) @(negedge clk);
        check("tick_999", {6'b0, bus_slow.curr_time}, 24'h0);
        @(negedge clk);
        check("tick_1000", {6'b0, bus_slow.curr_time}, {6'b0, hms(0, 0, 1)});
        repeat (997) @(negedge clk);
        set_btn(M_ISEC);
        @(negedge clk) set_btn(7'b0);
        @(negedge clk);
        check("tick_1999", {6'b0, bus_slow.curr_time}, {6'b0, hms(0, 0, 1)});
        @(negedge clk);
        check("tick_adj", {6'b0, bus_slow.curr_time}, {6'b0, hms(0, 0, 2)});
        @(negedge clk);
        check("tick_pending", {6'b0, bus_slow.curr_time}, {6'b0, hms(0, 0, 3)});
        $display("tick: time=%05h", bus_slow.curr_time);

        begin
            int w;
            w = 0;
            while (!fast_done && w < 90000) begin
                @(negedge clk);
                w++;
            end
            check("fast_done", {23'b0, fast_done}, 24'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
